score_tracker: RTL and testbench
================================

# score_tracker

Game-score engine for Dino-Jumper. It sits directly upstream of the 4-digit seven-segment driver, which consumes its 14-bit binary `disp_score`. The block runs the game-phase state machine (idle / running / game-over) and advances the score on a prescaled tick. It also derives a difficulty level for the obstacle generator and keeps a session high score.

## Interface
Parameters:
- `TICK_DIV`, 10_000_000: `clk` cycles per score increment (10 Hz at 100 MHz); legal range ≥ 2.
- `MAX_SCORE`, 9999: saturation value; must be ≤ 16383.
- `LEVEL_STEP`, 100: points per difficulty level.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse, synchronous to `clk`: begin a new game.
- `collision`  in  1  synchronous, sampled every cycle: dino hit an obstacle.
- `score`  out  14  current game score, binary.
- `high_score`  out  14  best score since reset.
- `disp_score`  out  14  value to feed the seven-segment driver.
- `level`  out  3  difficulty level, 0..7.
- `running`  out  1  high while in S_RUN.
- `new_record`  out  1  high in S_OVER when the last game set a new high score.

## Operation
- States: S_IDLE, S_RUN, S_OVER. All outputs are registered except `disp_score`, which is a combinational mux of registered values.
- Reset value: state S_IDLE; `score`, `high_score`, `level`, `running`, `new_record` all 0; prescaler 0; level sub-counter 0.
- S_IDLE:
  - `start` → S_RUN; `score`, `level`, prescaler and sub-counter clear to 0.
  - `collision` is ignored.
- S_RUN:
  - The prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1 it wraps to 0 and asserts an internal `tick`.
  - On `tick`, if `score` < MAX_SCORE then `score` += 1; otherwise `score` holds at MAX_SCORE.
  - Level sub-counter counts accepted increments 0..LEVEL_STEP-1. When it wraps, `level` += 1, saturating at 7. No divider is used.
  - `collision` → S_OVER. A collision beats a `tick` in the same cycle: that increment is dropped.
  - `start` is ignored.
- S_OVER:
  - `score` and `level` freeze.
  - On the transition edge, if `score` > `high_score`, then `high_score` ← `score` and `new_record` ← 1. Equal scores do not count as a record.
  - `start` → S_RUN with the same clears as from S_IDLE; `new_record` also clears.
  - `collision` is ignored.
- `start` and `collision` in the same cycle: state-dependent. In S_IDLE/S_OVER `start` wins; in S_RUN `collision` wins.
- `disp_score`: equals `high_score` in S_IDLE, `score` in S_RUN and S_OVER.
- Width rules: all arithmetic is 14-bit unsigned. Saturation is checked before the increment, so there is no wrap past MAX_SCORE.
- When `rst_n` is asserted mid-game, all registers clear immediately. `high_score` is lost.

## Timing
- `start` sampled at edge N → `running` = 1 and `score` = 0 after edge N.
- The first increment happens TICK_DIV cycles after the `start` edge. Increments then repeat every TICK_DIV cycles.
- `score` changes on the edge after the prescaler reaches TICK_DIV-1. `level` changes on that same edge.
- `collision` sampled at edge N → after edge N: `running` = 0, `high_score` and `new_record` updated. Latency is 1 cycle.
- `disp_score` follows state with zero added latency.

## Configuration
- `SCORE_HIGH_SCORE_EN` defined:
  - The `high_score` register and comparator are built.
  - `new_record` is live.
  - `disp_score` shows `high_score` in S_IDLE.
- `SCORE_HIGH_SCORE_EN` undefined:
  - No high-score logic is synthesised.
  - `high_score` and `new_record` are tied to 0.
  - `disp_score` = `score` in every state. The port list is unchanged.

## Structure
- Package `dino_score_pkg` holds:
  - `score_state_t` enum: S_IDLE, S_RUN, S_OVER.
  - `SCORE_W` = 14.
  - `LEVEL_W` = 3.
  - `LEVEL_MAX` = 7.
- Sub-module `tick_prescaler`:
  - Ports: `clk`, `rst_n`, `clr`, `en`, `tick`; parameter `DIV`.
  - Counts only while `en`; `clr` zeroes it synchronously.
  - `score_tracker` drives `en` = running and `clr` = accepted `start`.

## Test plan
Bench parameters: TICK_DIV = 4, LEVEL_STEP = 3, MAX_SCORE = 10.
1. Reset, pulse `start`, wait 12 cycles → `score` steps 1, 2, 3 at cycles 4, 8, 12; `level` = 1 at cycle 12; `running` = 1.
2. Run to 15 ticks → `score` saturates at 10 and holds; `level` = 3.
3. `collision` coincident with a tick at `score` = 5 → `score` stays 5; next cycle: S_OVER, `high_score` = 5, `new_record` = 1.
4. New game ending at `score` = 5 → `high_score` stays 5, `new_record` = 0. Third game ending at 7 → `high_score` = 7, `new_record` = 1.
5. In S_IDLE, `disp_score` = `high_score`. Assert `rst_n` = 0 mid-run → all outputs 0 asynchronously, state S_IDLE.
6. `start` during S_RUN at `score` = 2 → ignored, count continues. `collision` in S_IDLE → ignored. With the macro undefined, `high_score` = 0 throughout.

Source files
------------

// File: rtl/dino_score_pkg.sv
// Shared types and widths for the Dino-Jumper score engine.
package dino_score_pkg;

  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned LEVEL_W   = 3;
  localparam int unsigned LEVEL_MAX = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } score_state_t;

  // Saturating +1 on the difficulty level.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
    if (lvl == LEVEL_W'(LEVEL_MAX)) begin
      return lvl;
    end
    return lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter that pulses tick on its last count.
module tick_prescaler #(
  parameter int unsigned DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // Tick is asserted on the cycle the counter sits at DIV-1 while enabled.
  assign tick = en && (count == LAST);

  // Count while enabled, wrap on tick, synchronous clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Dino-Jumper game-score engine: game-phase FSM, prescaled score counter,
// difficulty level and optional session high score.
// Optional feature macro: SCORE_HIGH_SCORE_EN (high score / new record).
module score_tracker
  import dino_score_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned MAX_SCORE  = 9999,
  parameter int unsigned LEVEL_STEP = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               collision,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] disp_score,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               new_record
);

  localparam int unsigned SUB_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(MAX_SCORE);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(LEVEL_STEP - 1);

  score_state_t     state;
  logic [SUB_W-1:0] sub_cnt;
  logic             tick;
  logic             accept_start;
  logic             game_end;

  // Start is only honoured outside a running game; collision only inside one.
  assign accept_start = start && (state != S_RUN);
  assign game_end     = collision && (state == S_RUN);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_start),
    .en    (running),
    .tick  (tick)
  );

  // Game-phase FSM with score, level and level sub-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      score   <= '0;
      level   <= '0;
      sub_cnt <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state   <= S_RUN;
            score   <= '0;
            level   <= '0;
            sub_cnt <= '0;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (collision) begin
            // Collision drops any tick landing on the same cycle.
            state   <= S_OVER;
            running <= 1'b0;
          end else if (tick && (score < SCORE_SAT)) begin
            score <= score + SCORE_W'(1);
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= '0;
              level   <= level_inc(level);
            end else begin
              sub_cnt <= sub_cnt + SUB_W'(1);
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  // Capture a strictly better score as the game ends; cleared by a new game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else if (accept_start) begin
      new_record <= 1'b0;
    end else if (game_end) begin
      if (score > high_score) begin
        high_score <= score;
        new_record <= 1'b1;
      end else begin
        new_record <= 1'b0;
      end
    end
  end

  // Idle screen shows the best score, otherwise the live game score.
  assign disp_score = (state == S_IDLE) ? high_score : score;
`else
  assign high_score = '0;
  assign new_record = 1'b0;
  assign disp_score = score;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker
// (TICK_DIV = 4, LEVEL_STEP = 3, MAX_SCORE = 10).
module tb_score_tracker;

`ifdef SCORE_HIGH_SCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        collision;
  logic [13:0] score;
  logic [13:0] high_score;
  logic [13:0] disp_score;
  logic [2:0]  level;
  logic        running;
  logic        new_record;

  int n_checks = 0;
  int n_fail   = 0;

  score_tracker #(
    .TICK_DIV   (4),
    .MAX_SCORE  (10),
    .LEVEL_STEP (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .collision  (collision),
    .score      (score),
    .high_score (high_score),
    .disp_score (disp_score),
    .level      (level),
    .running    (running),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks every output; high-score expectations collapse to 0 without the feature.
  task automatic check_all(input string tag, input int e_sc, input int e_lv, input bit e_run,
                           input int e_hi_raw, input bit e_nr_raw, input bit e_idle);
    int  e_hi;
    bit  e_nr;
    int  e_disp;
    e_hi   = HI_EN ? e_hi_raw : 0;
    e_nr   = HI_EN ? e_nr_raw : 1'b0;
    e_disp = (HI_EN && e_idle) ? e_hi : e_sc;
    chk({tag, ".score"},      16'(score),      16'(e_sc));
    chk({tag, ".level"},      16'(level),      16'(e_lv));
    chk({tag, ".running"},    16'(running),    16'(e_run));
    chk({tag, ".high_score"}, 16'(high_score), 16'(e_hi));
    chk({tag, ".new_record"}, 16'(new_record), 16'(e_nr));
    chk({tag, ".disp_score"}, 16'(disp_score), 16'(e_disp));
  endtask

  initial begin
    int e;
    rst_n     = 1'b0;
    start     = 1'b0;
    collision = 1'b0;
    #23;
    check_all("reset", 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    step();
    check_all("idle", 0, 0, 0, 0, 0, 1);

    // Collision while idle is ignored.
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_all("idle_coll", 0, 0, 0, 0, 0, 1);

    // Game 1: score every 4 cycles, level every 3 points, saturate at 10.
    // A start pulse mid-run (score 2) must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("g1_start", 0, 0, 1, 0, 0, 0);
    for (int c = 1; c <= 60; c++) begin
      start = (c == 9);
      step();
      start = 1'b0;
      e = (c / 4 > 10) ? 10 : c / 4;
      check_all("g1_run", e, e / 3, 1, 0, 0, 0);
    end

    // Asynchronous reset mid-game clears everything without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("g1_rst", 0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b1;
    step();
    check_all("g1_post_rst", 0, 0, 0, 0, 0, 1);

    // Game 2: collision on the tick that would make 5 -> 6; increment dropped.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 23; c++) step();
    check_all("g2_pre", 5, 1, 1, 0, 0, 0);
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_all("g2_over", 5, 1, 0, 5, 1, 0);
    collision = 1'b1;
    for (int c = 0; c < 5; c++) step();
    collision = 1'b0;
    check_all("g2_frozen", 5, 1, 0, 5, 1, 0);

    // Game 3: ends at an equal score -> not a record.
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("g3_start", 0, 0, 1, 5, 0, 0);
    for (int c = 1; c <= 20; c++) step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_all("g3_over", 5, 1, 0, 5, 0, 0);

    // Game 4: ends at 7 -> new record.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 28; c++) step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_all("g4_over", 7, 2, 0, 7, 1, 0);

    // Start and collision together in S_OVER: start wins.
    start     = 1'b1;
    collision = 1'b1;
    step();
    start     = 1'b0;
    collision = 1'b0;
    check_all("g5_both_over", 0, 0, 1, 7, 0, 0);
    for (int c = 1; c <= 9; c++) step();
    check_all("g5_run", 2, 0, 1, 7, 0, 0);

    // Start and collision together in S_RUN: collision wins.
    start     = 1'b1;
    collision = 1'b1;
    step();
    start     = 1'b0;
    collision = 1'b0;
    check_all("g5_both_run", 2, 0, 0, 7, 0, 0);

    // Game 6: reset mid-run also loses the high score.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) step();
    check_all("g6_run", 2, 0, 1, 7, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("g6_rst", 0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b1;
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_all("g6_idle", 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
